sprite_walk_engine: RTL

SPRITE_WALK_ENGINE -- requirements
Module: sprite_walk_engine

---
 rtl/pokemon_pkg.sv | 53 +++++
 rtl/sprite_walk_engine_walk_fsm.sv | 137 +++++++++++++
 rtl/sprite_walk_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pokemon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pokemon_pkg                                                     |
// | Purpose  : Shared types for the sprite walk engine: walk direction         |
// |            encoding, animation phase enum, sprite-sheet base columns and   |
// |            the helper that maps (direction, phase) to a sheet column.      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pokemon_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    REST_A = 2'd0,
    STEP_A = 2'd1,
    REST_B = 2'd2,
    STEP_B = 2'd3
  } phase_t;

  // First sheet column of each direction's three-frame strip.
  localparam logic [3:0] c_BASE_DOWN  = 4'd0;
  localparam logic [3:0] c_BASE_LEFT  = 4'd3;
  localparam logic [3:0] c_BASE_UP    = 4'd6;
  localparam logic [3:0] c_BASE_RIGHT = 4'd9;

  // The strip is stored as (step-left, stand, step-right); a walk cycle
  // visits stand, step, stand, other-step, hence offsets 1,0,1,2.
  function automatic logic [3:0] anim_column(input dir_t d, input phase_t p);
    logic [3:0] base;
    logic [3:0] offs;
    case (d)
      DIR_UP:    base = c_BASE_UP;
      DIR_RIGHT: base = c_BASE_RIGHT;
      DIR_DOWN:  base = c_BASE_DOWN;
      default:   base = c_BASE_LEFT;
    endcase
    case (p)
      REST_A:  offs = 4'd1;
      STEP_A:  offs = 4'd0;
      REST_B:  offs = 4'd1;
      default: offs = 4'd2;
    endcase
    return base + offs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_walk_engine_walk_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : walk_fsm                                                        |
// | Purpose  : Per-frame walk animation and camera motion. Advances only on    |
// |            the frame tick; camera saturates at its bounds.                 |
// | Ports    : Clk, Reset     - clock, synchronous active-high reset           |
// |            tick           - one-cycle frame strobe                         |
// |            moving         - walk request                                   |
// |            direction[1:0] - requested direction (pokemon_pkg::dir_t)       |
// |            run            - run request (used with SPRITE_WALK_RUN_EN)     |
// |            cam_x, cam_y   - signed 13-bit camera position                  |
// |            anim_col[3:0]  - sprite-sheet column of the current frame       |
// | Config   : SPRITE_WALK_RUN_EN - when defined, run doubles step and delay   |
// |            advance; otherwise run is ignored.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module walk_fsm
  import pokemon_pkg::*;
#(
  parameter int ANIM_DIV = 8,
  parameter int CAM_X0   = 100,
  parameter int CAM_Y0   = 100,
  parameter int CAM_XMIN = -311,
  parameter int CAM_XMAX = 952,
  parameter int CAM_YMIN = -340,
  parameter int CAM_YMAX = 595
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               moving,
  input  logic [1:0]         direction,
  input  logic               run,
  output logic signed [12:0] cam_x,
  output logic signed [12:0] cam_y,
  output logic [3:0]         anim_col
);

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic signed [13:0] c_XMIN = 14'(CAM_XMIN);
  localparam logic signed [13:0] c_XMAX = 14'(CAM_XMAX);
  localparam logic signed [13:0] c_YMIN = 14'(CAM_YMIN);
  localparam logic signed [13:0] c_YMAX = 14'(CAM_YMAX);

  dir_t               r_dir,   w_dir_next;
  phase_t             r_phase, w_phase_next;
  logic [DW-1:0]      r_delay, w_delay_next;
  logic signed [12:0] r_cam_x, w_cam_x_next;
  logic signed [12:0] r_cam_y, w_cam_y_next;
  logic [3:0]         r_anim_col;

  logic               w_fast;
  logic signed [13:0] w_step;
  logic [DW:0]        w_delay_sum;
  logic [DW:0]        w_delay_wrap;
  logic signed [13:0] w_x_try, w_y_try;
  logic signed [13:0] w_x_sat, w_y_sat;

`ifdef SPRITE_WALK_RUN_EN
  assign w_fast = run;
`else
  logic w_unused_run;
  assign w_unused_run = run;
  assign w_fast       = 1'b0;
`endif

  always_comb begin
    w_step       = w_fast ? 14'sd2 : 14'sd1;
    w_delay_sum  = {1'b0, r_delay} + (w_fast ? (DW+1)'(2) : (DW+1)'(1));
    w_delay_wrap = (w_delay_sum >= (DW+1)'(ANIM_DIV)) ?
                   (w_delay_sum - (DW+1)'(ANIM_DIV)) : w_delay_sum;

    // Widen by one bit so the step never wraps before saturation.
    w_x_try = {r_cam_x[12], r_cam_x};
    w_y_try = {r_cam_y[12], r_cam_y};
    case (r_dir)
      DIR_UP:    w_y_try = w_y_try - w_step;
      DIR_RIGHT: w_x_try = w_x_try + w_step;
      DIR_DOWN:  w_y_try = w_y_try + w_step;
      default:   w_x_try = w_x_try - w_step;
    endcase
    if (w_x_try > c_XMAX)      w_x_sat = c_XMAX;
    else if (w_x_try < c_XMIN) w_x_sat = c_XMIN;
    else                       w_x_sat = w_x_try;
    if (w_y_try > c_YMAX)      w_y_sat = c_YMAX;
    else if (w_y_try < c_YMIN) w_y_sat = c_YMIN;
    else                       w_y_sat = w_y_try;

    w_dir_next   = r_dir;
    w_phase_next = r_phase;
    w_delay_next = r_delay;
    w_cam_x_next = r_cam_x;
    w_cam_y_next = r_cam_y;
    if (tick) begin
      if (!moving) begin
        w_phase_next = REST_A;
        w_delay_next = '0;
      end else if (direction != r_dir) begin
        // Turning in place: face the new way, no camera motion.
        w_dir_next   = dir_t'(direction);
        w_phase_next = REST_A;
        w_delay_next = '0;
      end else begin
        if (r_delay == '0)
          w_phase_next = phase_t'(r_phase + 2'd1);
        w_delay_next = w_delay_wrap[DW-1:0];
        w_cam_x_next = w_x_sat[12:0];
        w_cam_y_next = w_y_sat[12:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dir      <= DIR_DOWN;
      r_phase    <= REST_A;
      r_delay    <= '0;
      r_cam_x    <= 13'(CAM_X0);
      r_cam_y    <= 13'(CAM_Y0);
      r_anim_col <= anim_column(DIR_DOWN, REST_A);
    end else begin
      r_dir      <= w_dir_next;
      r_phase    <= w_phase_next;
      r_delay    <= w_delay_next;
      r_cam_x    <= w_cam_x_next;
      r_cam_y    <= w_cam_y_next;
      r_anim_col <= anim_column(w_dir_next, w_phase_next);
    end
  end

  assign cam_x    = r_cam_x;
  assign cam_y    = r_cam_y;
  assign anim_col = r_anim_col;

endmodule
`default_nettype wire

// File: rtl/sprite_walk_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sprite_walk_engine                                              |
// | Purpose  : Walking-sprite renderer helper. Synchronises VS into a frame    |
// |            tick driving the walk FSM, and generates registered sprite-     |
// |            sheet and map texel addresses for the current pixel.            |
// | Ports    : Clk, Reset        - clock, synchronous active-high reset        |
// |            VS                - vertical sync, asynchronous to Clk          |
// |            Moving, Direction - walk request and direction                  |
// |            Run               - run request                                 |
// |            DrawX, DrawY      - current pixel, blank = 1 in active video    |
// |            char_here/addr    - sprite box hit and sheet address (1 clk)    |
// |            map_valid/addr    - map hit and map address (1 clk)             |
// |            cam_x, cam_y      - signed camera position                      |
// |            anim_col          - sprite-sheet column                         |
// | Config   : SPRITE_WALK_RUN_EN - enables run (double speed) in walk_fsm.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sprite_walk_engine
  import pokemon_pkg::*;
#(
  parameter int SHEET_W    = 228,
  parameter int SPR_W      = 19,
  parameter int SPR_H      = 29,
  parameter int SPR_X0     = 311,
  parameter int SPR_Y0     = 340,
  parameter int MAP_W      = 320,
  parameter int MAP_H      = 240,
  parameter int SCALE_LOG2 = 2,
  parameter int ANIM_DIV   = 8,
  parameter int CAM_X0     = 100,
  parameter int CAM_Y0     = 100,
  parameter int CAM_XMIN   = -311,
  parameter int CAM_XMAX   = 952,
  parameter int CAM_YMIN   = -340,
  parameter int CAM_YMAX   = 595
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               VS,
  input  logic               Moving,
  input  logic [1:0]         Direction,
  input  logic               Run,
  input  logic [10:0]        DrawX,
  input  logic [10:0]        DrawY,
  input  logic               blank,
  output logic               char_here,
  output logic [12:0]        char_addr,
  output logic [18:0]        map_addr,
  output logic               map_valid,
  output logic signed [12:0] cam_x,
  output logic signed [12:0] cam_y,
  output logic [3:0]         anim_col
);

  // VS synchroniser plus one stage of history for rising-edge detection.
  logic r_vs_meta, r_vs_sync, r_vs_prev;
  logic w_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= VS;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_tick = r_vs_sync & ~r_vs_prev;

  walk_fsm #(
    .ANIM_DIV (ANIM_DIV),
    .CAM_X0   (CAM_X0),
    .CAM_Y0   (CAM_Y0),
    .CAM_XMIN (CAM_XMIN),
    .CAM_XMAX (CAM_XMAX),
    .CAM_YMIN (CAM_YMIN),
    .CAM_YMAX (CAM_YMAX)
  ) u_walk_fsm (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (w_tick),
    .moving    (Moving),
    .direction (Direction),
    .run       (Run),
    .cam_x     (cam_x),
    .cam_y     (cam_y),
    .anim_col  (anim_col)
  );

  // Sprite box and sheet address. Arithmetic is kept at output width;
  // truncation is harmless because the in-box address always fits.
  logic        w_in_box;
  logic [10:0] w_rel_x, w_rel_y;
  logic [12:0] w_char_sum;

  always_comb begin
    w_in_box   = (DrawX >= 11'(SPR_X0)) && (DrawX < 11'(SPR_X0 + SPR_W)) &&
                 (DrawY >= 11'(SPR_Y0)) && (DrawY < 11'(SPR_Y0 + SPR_H));
    w_rel_x    = DrawX - 11'(SPR_X0);
    w_rel_y    = DrawY - 11'(SPR_Y0);
    w_char_sum = 13'(SHEET_W) * 13'(w_rel_y) + 13'(w_rel_x) +
                 13'(anim_col) * 13'(SPR_W);
  end

  // Map lookup: screen pixel offset by camera, scaled down to map texels.
  // Uses the current (pre-tick) camera so a tick and a pixel in the same
  // cycle see consistent values.
  logic signed [12:0] w_mx, w_my;
  logic [11:0]        w_tx, w_ty;
  logic               w_map_ok;
  logic [18:0]        w_map_idx;

  always_comb begin
    w_mx      = $signed({2'b00, DrawX}) + cam_x;
    w_my      = $signed({2'b00, DrawY}) + cam_y;
    w_tx      = w_mx[11:0] >> SCALE_LOG2;
    w_ty      = w_my[11:0] >> SCALE_LOG2;
    w_map_ok  = blank && !w_mx[12] && !w_my[12] &&
                (w_tx < 12'(MAP_W)) && (w_ty < 12'(MAP_H));
    w_map_idx = 19'(w_ty) * 19'(MAP_W) + 19'(w_tx);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      char_here <= 1'b0;
      char_addr <= '0;
      map_valid <= 1'b0;
      map_addr  <= '0;
    end else begin
      char_here <= w_in_box;
      char_addr <= w_in_box ? w_char_sum : '0;
      map_valid <= w_map_ok;
      map_addr  <= w_map_ok ? w_map_idx : '0;
    end
  end

endmodule
`default_nettype wire
